// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory port.
// Contents:
//   ADDR_W, DATA_W    bus widths (data fixed at 32, four byte lanes)
//   BHO_*             Byte_Half_OpM encodings (2'b11 behaves as word)
//   lsu_state_e       port FSM states
//   is_aligned()      natural-alignment test for an access size and low address bits
package lsu_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] BHO_WORD = 2'b00;
  localparam logic [1:0] BHO_BYTE = 2'b01;
  localparam logic [1:0] BHO_HALF = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_e;

  function automatic logic is_aligned(input logic [1:0] op, input logic [1:0] lane);
    case (op)
      BHO_BYTE: return 1'b1;
      BHO_HALF: return ~lane[0];
      default:  return lane == 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request/grant/response data bus between the load/store port and memory.
// Signals:
//   bus_req, bus_we, bus_addr, bus_wdata, bus_be   request side (driven by master)
//   bus_gnt, bus_rvalid, bus_rdata                 response side (driven by slave)
// Modports: master (load/store port), slave (memory).
interface lsu_mem_port_if;
  import lsu_pkg::*;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_gnt, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load data alignment: selects the addressed byte/halfword lane of a
// 32-bit read word and sign- or zero-extends it to 32 bits; words pass through.
// Ports:
//   i_rdata  raw bus read data
//   i_lane   low two address bits of the access
//   i_op     Byte_Half_Op encoding (2'b11 treated as word)
//   i_sign   1 sign-extend, 0 zero-extend
//   o_data   extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_op,
  input  logic        i_sign,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    unique case (i_lane)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_op)
      BHO_BYTE: o_data = {{24{i_sign & w_byte[7]}}, w_byte};
      BHO_HALF: o_data = {{16{i_sign & w_half[15]}}, w_half};
      default:  o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Memory-stage load/store port. Accepts an aligned load or store from the M stage,
// issues it on the request/grant/response bus, stalls the pipeline until it completes
// and returns extended load data. Misaligned accesses are flagged and never issued.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   MemReadM, MemWriteM           load / store request (both set: store)
//   Byte_Half_OpM, signM          access size and load extension
//   ALUResultM, WriteDataM        byte address and store data
//   StallLSU                      hold F/D/E/M while a transaction is in flight
//   ReadDataW, LoadValidW         load result and its one-cycle valid pulse
//   MisalignM                     one-cycle misaligned-access flag
//   bus                           memory bus (master side)
module lsu_mem_port
  import lsu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 MemReadM,
  input  logic                 MemWriteM,
  input  logic [1:0]           Byte_Half_OpM,
  input  logic                 signM,
  input  logic [ADDR_W-1:0]    ALUResultM,
  input  logic [DATA_W-1:0]    WriteDataM,
  output logic                 StallLSU,
  output logic [DATA_W-1:0]    ReadDataW,
  output logic                 LoadValidW,
  output logic                 MisalignM,
  lsu_mem_port_if.master       bus
);

  lsu_state_e        r_state, w_next_state;
  logic              r_we, r_sign;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [3:0]        r_be;
  logic [1:0]        r_op, r_lane;

  logic              w_mem_op, w_aligned, w_accept;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata, w_load_data;

  assign w_mem_op  = MemReadM | MemWriteM;
  assign w_aligned = is_aligned(Byte_Half_OpM, ALUResultM[1:0]);
  assign w_accept  = (r_state == StIdle) & w_mem_op & w_aligned;

  // Store formatting: replicate the store data across every lane so the byte
  // enables alone pick the destination bytes.
  always_comb begin
    case (Byte_Half_OpM)
      BHO_BYTE: begin
        w_be    = 4'b0001 << ALUResultM[1:0];
        w_wdata = {4{WriteDataM[7:0]}};
      end
      BHO_HALF: begin
        w_be    = 4'b0011 << {ALUResultM[1], 1'b0};
        w_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .i_rdata (bus.bus_rdata),
    .i_lane  (r_lane),
    .i_op    (r_op),
    .i_sign  (r_sign),
    .o_data  (w_load_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_next_state = StReq;
      StReq:   if (bus.bus_gnt) w_next_state = r_we ? StDone : StWait;
      StWait:  if (bus.bus_rvalid) w_next_state = StDone;
      StDone:  w_next_state = StIdle;
      default: w_next_state = StIdle;
    endcase
  end

  // FSM outputs. The IDLE-cycle flags are combinational on the M-stage inputs, so they
  // are gated by reset to keep every output low while reset is held.
  always_comb begin
    StallLSU       = reset_n & (w_accept | (r_state == StReq) | (r_state == StWait));
    MisalignM      = reset_n & (r_state == StIdle) & w_mem_op & ~w_aligned;
    LoadValidW     = (r_state == StDone) & ~r_we;
    ReadDataW      = r_rdata;
    bus.bus_req    = (r_state == StReq);
    bus.bus_we     = r_we;
    bus.bus_addr   = r_addr;
    bus.bus_wdata  = r_wdata;
    bus.bus_be     = r_be;
  end

  // Request capture and load result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_sign  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 4'b0000;
      r_op    <= BHO_WORD;
      r_lane  <= 2'b00;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= MemWriteM;
        r_sign  <= signM;
        r_addr  <= {ALUResultM[ADDR_W-1:2], 2'b00};
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_op    <= Byte_Half_OpM;
        r_lane  <= ALUResultM[1:0];
      end
      if ((r_state == StWait) && bus.bus_rvalid) begin
        r_rdata <= w_load_data;
      end
    end
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store port sitting in the Memory stage, consuming the decoded memory controls (MemWrite, load select, Byte_Half_Op, sign) and driving a request/grant/response data bus. It generates byte enables and lane-replicated store data, extracts and sign/zero-extends load data, stalls the pipeline while a bus transaction is outstanding, and flags misaligned accesses without issuing them.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed at 32; byte enables are 4 bits)

- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- Byte_Half_OpM  in  2  00 word, 01 byte, 10 half, 11 treated as word
- signM  in  1  1 sign-extend, 0 zero-extend (loads only)
- ALUResultM  in  ADDR_W  effective byte address
- WriteDataM  in  DATA_W  store data (low bits significant)
- StallLSU  out  1  hold F/D/E/M stages
- ReadDataW  out  DATA_W  extended load result
- LoadValidW  out  1  one-cycle pulse, ReadDataW valid
- MisalignM  out  1  one-cycle misalignment flag
- bus_req  out  1  request valid
- bus_we  out  1  1 write, 0 read
- bus_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- bus_wdata  out  DATA_W  lane-replicated store data
- bus_be  out  4  byte enables
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  DATA_W  read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if (MemReadM|MemWriteM) and aligned, register op/address/data, StallLSU=1 combinationally, -> REQ. Both asserted: treated as store.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00; byte always aligned. Misaligned: MisalignM=1 for that cycle, no bus activity, no stall, stay IDLE.
- REQ: bus_req=1 with stable bus_we/addr/wdata/be until bus_gnt. On gnt: store -> DONE, load -> WAIT. bus_rvalid in REQ ignored.
- WAIT: bus_req=0; on bus_rvalid capture extended data into ReadDataW -> DONE.
- DONE: StallLSU=0, LoadValidW=1 if load, -> IDLE. Pipeline advances; next M-stage op is examined in following IDLE cycle.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- wdata: byte {4{WriteDataM[7:0]}}; half {2{WriteDataM[15:0]}}; word WriteDataM.
- Load extract: byte lane addr[1:0], half lane addr[1]; extend per signM to 32 bits; word passes through.
- ReadDataW holds last load value until next load completes.
- Reset (any state, async): state IDLE; all outputs 0 (bus_req, bus_we, bus_addr, bus_wdata, bus_be, StallLSU, ReadDataW, LoadValidW, MisalignM). In-flight transaction abandoned; late bus_rvalid after reset ignored.

## Timing
- StallLSU high from accept cycle through REQ/WAIT; low in DONE.
- Store, gnt immediate: accept c0, REQ+gnt c1, DONE c2 → stall 2 cycles.
- Load, gnt c1, rvalid c2: DONE c3 with LoadValidW and ReadDataW valid → stall 3 cycles.
- Each gnt wait cycle or rvalid wait cycle extends stall by one.
- MisalignM combinational in IDLE, zero latency.

## Structure
- Package lsu_pkg: state enum (IDLE, REQ, WAIT, DONE), localparams for Byte_Half_Op encodings (BHO_WORD=2'b00, BHO_BYTE=2'b01, BHO_HALF=2'b10).
- Sub-module lsu_load_align: combinational lane select and sign/zero extension (rdata, addr[1:0], op, sign → 32-bit result); FSM and store formatting in top.

## Test plan
- sb addr 0x1003, data 0x000000A5, gnt immediate -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x1000, StallLSU 2 cycles.
- lh signed addr 0x2002, bus_rdata=0x8001_1234, rvalid 2 cycles after gnt -> ReadDataW=0xFFFF8001, LoadValidW one pulse, stall 4 cycles.
- lbu addr 0x2001, bus_rdata=0x0000_F000 -> ReadDataW=0x000000F0; lb same -> 0xFFFFFFF0.
- lw addr 0x3002 -> MisalignM=1 one cycle, bus_req stays 0, StallLSU 0; sh addr 0x3001 same.
- sw addr 0x4000, bus_gnt withheld 3 cycles -> bus_req/addr/wdata/be stable throughout, stall 5 cycles total.
- reset_n low during WAIT -> all outputs 0 immediately; subsequent rvalid produces no LoadValidW; next lw completes normally.
